// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for byte_word_packer.
// master drives bytes and accepts words; slave is the packer.
interface byte_word_packer_if #(
  parameter int N = 32
);
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [N-1:0] out_word;
  logic [3:0]   out_be;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   lane;

  modport master (
    output in_byte, in_valid, flush, out_ready,
    input  in_ready, out_word, out_be, out_valid, lane
  );

  modport slave (
    input  in_byte, in_valid, flush, out_ready,
    output in_ready, out_word, out_be, out_valid, lane
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words with byte enables, lane 1 = bits 7:0.
// Define PACKER_FLUSH_EN to let flush emit a partially filled word.
module byte_word_packer_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] q,
  output logic       be
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q  <= '0;
      be <= 1'b0;
    end else if (wr) begin
      q  <= din;
      be <= 1'b1;
    end
  end
endmodule

module byte_word_packer #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  byte_word_packer_if.slave bus
);
  localparam int NUM_LANES = N / 8;

  if (N != 32) begin : g_bad_n
    $error("byte_word_packer: only N=32 is supported");
  end

  typedef enum logic {FILL, HOLD} state_t;

  state_t state, state_nx;
  logic [2:0] lane, lane_nx;
  logic       out_valid, out_valid_nx;
  logic       accept, flush_go, clr;
  logic [NUM_LANES-1:0]      wr_sel;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] lane_q;

  assign accept = (state == FILL) && bus.in_valid;
  assign clr    = (state == HOLD) && bus.out_ready;

`ifdef PACKER_FLUSH_EN
  // A byte arriving with flush is written first, so lane 1 with a byte still emits.
  assign flush_go = (state == FILL) && bus.flush && (accept || lane != 3'd1);
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_go     = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    lane_nx      = lane;
    out_valid_nx = out_valid;
    case (state)
      FILL: begin
        if (accept)
          lane_nx = (lane == 3'd4) ? 3'd1 : lane + 3'd1;
        if ((accept && lane == 3'd4) || flush_go) begin
          state_nx     = HOLD;
          lane_nx      = 3'd1;
          out_valid_nx = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nx     = FILL;
          out_valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx     = FILL;
        lane_nx      = 3'd1;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      lane      <= 3'd1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      lane      <= lane_nx;
      out_valid <= out_valid_nx;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign wr_sel[k] = accept && (lane == 3'(k + 1));
    byte_word_packer_lane u_lane (
      .clk (clk),
      .rst (rst),
      .wr  (wr_sel[k]),
      .clr (clr),
      .din (bus.in_byte),
      .q   (lane_q[k]),
      .be  (be[k])
    );
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.out_word  = lane_q;
  assign bus.out_be    = be;
  assign bus.out_valid = out_valid;
  assign bus.lane      = lane;
endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: expected words queued as bytes are
// driven, popped by the handshake monitor.
module tb_byte_word_packer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   hs_cnt;

  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  be;
  } exp_t;
  exp_t sb[$];

  byte_word_packer_if #(.N(32)) bus ();

  byte_word_packer #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      exp_t e;
      hs_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h be %b, none expected", bus.out_word, bus.out_be);
      end else begin
        e = sb.pop_front();
        if (bus.out_word !== e.word || bus.out_be !== e.be) begin
          n_fail++;
          $display("FAIL word_out: got %h be %b, want %h be %b", bus.out_word, bus.out_be, e.word, e.be);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit ok;
    int n;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: byte %h not accepted in 50 cycles", b);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_be !== 4'b0 || bus.out_word !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b be=%b w=%h, want 0/0000/0", bus.out_valid, bus.out_be, bus.out_word);
    end
    n_checks++;
    if (bus.lane !== 3'd1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_lane: got lane=%0d rdy=%b, want 1/1", bus.lane, bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    sb.push_back({32'h44332211, 4'hf});
    send(8'h11); send(8'h22); send(8'h33);
    n_checks++;
    if (bus.lane !== 3'd4) begin
      n_fail++; $display("FAIL basic_lane4: got %0d want 4", bus.lane);
    end
    send(8'h44);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h44332211 || bus.out_be !== 4'hf) begin
      n_fail++;
      $display("FAIL basic_word: got v=%b w=%h be=%b, want 1/44332211/1111", bus.out_valid, bus.out_word, bus.out_be);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.lane !== 3'd1) begin
      n_fail++; $display("FAIL basic_hold: got rdy=%b lane=%0d, want 0/1", bus.in_ready, bus.lane);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL basic_release: got rdy=%b v=%b pending=%0d, want 1/0/0", bus.in_ready, bus.out_valid, sb.size());
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    sb.push_back({32'hDDCCBBAA, 4'hf});
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    bus.in_byte  = 8'h55;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hDDCCBBAA || bus.out_be !== 4'hf || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stable[%0d]: got v=%b w=%h be=%b rdy=%b", i, bus.out_valid, bus.out_word, bus.out_be, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.lane !== 3'd1) begin
      n_fail++; $display("FAIL bp_release: got rdy=%b lane=%0d, want 1/1", bus.in_ready, bus.lane);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.lane !== 3'd2 || bus.out_be !== 4'b0001 || bus.out_word !== 32'h55) begin
      n_fail++;
      $display("FAIL bp_held_byte: got lane=%0d be=%b w=%h, want 2/0001/00000055", bus.lane, bus.out_be, bus.out_word);
    end
    sb.push_back({32'h88776655, 4'hf});
    send(8'h66); send(8'h77); send(8'h88);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int  idx, cyc, hs0;
    bit  ok;
    bus.out_ready = 1'b1;
    sb.push_back({32'h04030201, 4'hf});
    sb.push_back({32'h08070605, 4'hf});
    hs0 = hs_cnt;
    idx = 0;
    cyc = 0;
    bus.in_byte  = 8'h01;
    bus.in_valid = 1'b1;
    while (cyc < 10) begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (ok) idx++;
      if (idx < 8) bus.in_byte = 8'(idx + 1);
      else bus.in_valid = 1'b0;
      if (cyc == 9) begin
        n_checks++;
        if (hs_cnt - hs0 != 1) begin
          n_fail++; $display("FAIL b2b_mid: got %0d words after 9 cycles, want 1", hs_cnt - hs0);
        end
      end
    end
    n_checks++;
    if (idx != 8 || hs_cnt - hs0 != 2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got bytes=%0d words=%0d pending=%0d, want 8/2/0", idx, hs_cnt - hs0, sb.size());
    end
  endtask

  task automatic test_reset_mid_word();
    bus.out_ready = 1'b1;
    send(8'hAA); send(8'hBB);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.lane !== 3'd1 || bus.out_be !== 4'b0 || bus.out_valid !== 1'b0 || bus.out_word !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got lane=%0d be=%b v=%b w=%h, want 1/0000/0/0", bus.lane, bus.out_be, bus.out_valid, bus.out_word);
    end
    sb.push_back({32'h04030201, 4'hf});
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL rst_mid_after: got %0d pending words, want 0", sb.size());
    end
  endtask

  task automatic test_reset_in_hold();
    int hs0;
    bus.out_ready = 1'b0;
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_hold_pre: got v=%b want 1", bus.out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.lane !== 3'd1 || bus.out_be !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_hold: got v=%b rdy=%b lane=%0d be=%b, want 0/1/1/0000", bus.out_valid, bus.in_ready, bus.lane, bus.out_be);
    end
    hs0 = hs_cnt;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (hs_cnt != hs0) begin
      n_fail++; $display("FAIL rst_hold_drop: got %0d words after reset, want 0", hs_cnt - hs0);
    end
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(8'h10); send(8'h20);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h00002010 || bus.out_be !== 4'b0011 || bus.lane !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_partial: got v=%b w=%h be=%b lane=%0d", bus.out_valid, bus.out_word, bus.out_be, bus.lane);
    end
    sb.push_back({32'h00002010, 4'b0011});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_empty: got v=%b rdy=%b, want 0/1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b0;
    send(8'h10); send(8'h20);
    bus.flush = 1'b1;
    send(8'h30);
    bus.flush = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h00302010 || bus.out_be !== 4'b0111) begin
      n_fail++;
      $display("FAIL flush_with_byte: got v=%b w=%h be=%b, want 1/00302010/0111", bus.out_valid, bus.out_word, bus.out_be);
    end
    sb.push_back({32'h00302010, 4'b0111});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    hs_cnt        = 0;
    rst           = 1'b1;
    bus.in_byte   = 8'h0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_reset_in_hold();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL final_drain: got %0d pending words, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
